pixel_plot_arbiter: RTL and testbench

//  Merges the pixel-write streams of NUM_SRC sprite drawers (enemy/player/bullet FSM+datapath pairs)

---
 rtl/pixel_plot_arbiter_pkg.sv | 24 ++
 rtl/pixel_plot_arbiter_if.sv | 31 +++
 rtl/pixel_plot_arbiter_rr_arbiter.sv | 70 +++++++
 rtl/pixel_plot_arbiter.sv | 84 ++++++++
 tb/tb_pixel_plot_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pixel_plot_arbiter_pkg.sv
// Shared VGA geometry and pixel bundle for the pixel plot arbiter.
// Target is the 160x120, 3-bit colour vga_adapter.
package pixel_plot_arbiter_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef struct packed {
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  function automatic logic off_screen(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y
  );
    return (x >= X_W'(SCREEN_W)) || (y >= Y_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/pixel_plot_arbiter_if.sv
// Drawer-side valid/ready bundle: one lane per sprite drawer,
// packed x/y/colour with source i at the i-th slice.
interface pixel_plot_arbiter_if
  import pixel_plot_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 2
);

  logic [NUM_SRC-1:0]          src_valid;
  logic [NUM_SRC-1:0]          src_ready;
  logic [NUM_SRC*X_W-1:0]      src_x;
  logic [NUM_SRC*Y_W-1:0]      src_y;
  logic [NUM_SRC*COLOUR_W-1:0] src_colour;

  modport master (
    output src_valid,
    output src_x,
    output src_y,
    output src_colour,
    input  src_ready
  );

  modport slave (
    input  src_valid,
    input  src_x,
    input  src_y,
    input  src_colour,
    output src_ready
  );

endinterface

// File: rtl/pixel_plot_arbiter_rr_arbiter.sv
// Round-robin arbiter with bounded bursts: owner/burst state in,
// one-hot grant out; state advances on every grant.
module pixel_plot_arbiter_rr_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       hold,
  input  logic [NUM_SRC-1:0]         req,
  output logic [NUM_SRC-1:0]         grant,
  output logic [$clog2(NUM_SRC)-1:0] sel,
  output logic                       fire,
  output logic [$clog2(NUM_SRC)-1:0] owner
);

  localparam int OW = $clog2(NUM_SRC);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST = BW'(MAX_BURST - 1);

  logic [BW-1:0] burst_cnt;
  logic          live;
  logic          keep;
  logic [OW-1:0] cand;

  // After reset no burst is in progress, so the scan starts at owner+1.
  assign keep = live && req[owner] && (burst_cnt < LAST);

  always_comb begin
    fire = 1'b0;
    sel  = owner;
    cand = owner;
    if (!hold) begin
      if (keep) begin
        fire = 1'b1;
      end else begin
        for (int k = 1; k <= NUM_SRC; k++) begin
          cand = OW'((int'(owner) + k) % NUM_SRC);
          if (!fire && req[cand]) begin
            fire = 1'b1;
            sel  = cand;
          end
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    if (fire) grant[sel] = 1'b1;
  end

  // The count saturates at LAST: any value >= LAST forces a rotation.
  always_ff @(posedge clock) begin
    if (reset) begin
      owner     <= OW'(NUM_SRC - 1);
      burst_cnt <= '0;
      live      <= 1'b0;
    end else if (fire) begin
      owner <= sel;
      live  <= 1'b1;
      if (sel == owner)
        burst_cnt <= (burst_cnt == LAST) ? burst_cnt
                                         : burst_cnt + 1'b1;
      else
        burst_cnt <= '0;
    end
  end

endmodule

// File: rtl/pixel_plot_arbiter.sv
// Merges NUM_SRC drawer pixel streams onto the vga_adapter plot port.
// Off-screen clipping is built when PIXEL_ARB_CLIP_EN is defined.
module pixel_plot_arbiter
  import pixel_plot_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = 2,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       hold,
  pixel_plot_arbiter_if.slave        src,
  output logic [X_W-1:0]             x,
  output logic [Y_W-1:0]             y,
  output logic [COLOUR_W-1:0]        colour,
  output logic                       plot,
  output logic [$clog2(NUM_SRC)-1:0] owner,
  output logic [CNT_W-1:0]           clip_cnt
);

  localparam int OW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] grant;
  logic [OW-1:0]      sel;
  logic               fire;
  logic               clipped;
  pixel_t             cur;
  pixel_t             px;

  pixel_plot_arbiter_rr_arbiter #(
    .NUM_SRC   (NUM_SRC),
    .MAX_BURST (MAX_BURST)
  ) u_arb (
    .clock (clock),
    .reset (reset),
    .hold  (hold),
    .req   (src.src_valid),
    .grant (grant),
    .sel   (sel),
    .fire  (fire),
    .owner (owner)
  );

  assign src.src_ready = grant;

  always_comb begin
    cur.x      = src.src_x[int'(sel)*X_W +: X_W];
    cur.y      = src.src_y[int'(sel)*Y_W +: Y_W];
    cur.colour = src.src_colour[int'(sel)*COLOUR_W +: COLOUR_W];
  end

`ifdef PIXEL_ARB_CLIP_EN
  assign clipped = off_screen(cur.x, cur.y);

  always_ff @(posedge clock) begin
    if (reset)
      clip_cnt <= '0;
    else if (fire && clipped && (clip_cnt != '1))
      clip_cnt <= clip_cnt + 1'b1;
  end
`else
  assign clipped  = 1'b0;
  assign clip_cnt = '0;
`endif

  // Clipped pixels still complete the handshake; only the strobe is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      px   <= '0;
      plot <= 1'b0;
    end else if (fire) begin
      px   <= cur;
      plot <= !clipped;
    end else begin
      plot <= 1'b0;
    end
  end

  assign x      = px.x;
  assign y      = px.y;
  assign colour = px.colour;

endmodule

// File: tb/tb_pixel_plot_arbiter.sv
// Self-checking bench for pixel_plot_arbiter (NUM_SRC=2, MAX_BURST=4).
// Reference model tracks owner/burst as plain integers.
module tb_pixel_plot_arbiter;

  localparam int N    = 2;
  localparam int MAXB = 4;
  localparam int CW   = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       hold;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic [0:0] owner;
  logic [CW-1:0] clip_cnt;

  pixel_plot_arbiter_if #(.NUM_SRC(N)) sv ();

  pixel_plot_arbiter #(
    .NUM_SRC   (N),
    .MAX_BURST (MAXB),
    .CNT_W     (CW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .hold     (hold),
    .src      (sv),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .plot     (plot),
    .owner    (owner),
    .clip_cnt (clip_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  int dx [N];
  int dy [N];
  int dc [N];

  bit m_init = 0;
  bit m_live;
  int m_owner, m_burst;
  int m_plot, m_x, m_y, m_col, m_clip;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int m_pick(logic [N-1:0] v, logic h);
    if (h) return -1;
    if (m_live && v[m_owner] && m_burst < MAXB - 1) return m_owner;
    for (int k = 1; k <= N; k++)
      if (v[(m_owner + k) % N]) return (m_owner + k) % N;
    return -1;
  endfunction

  task automatic step(logic [N-1:0] v, logic h, logic r);
    int  g;
    bit  clp;
    for (int i = 0; i < N; i++) begin
      sv.src_x[i*8 +: 8]      = 8'(dx[i]);
      sv.src_y[i*7 +: 7]      = 7'(dy[i]);
      sv.src_colour[i*3 +: 3] = 3'(dc[i]);
    end
    sv.src_valid = v;
    hold  = h;
    reset = r;
    #1;
    g = m_init ? m_pick(v, h) : -1;
    if (m_init) chk("ready", 32'(sv.src_ready), (g < 0) ? 0 : (1 << g));
    @(posedge clock);
    if (r) begin
      m_init = 1; m_live = 0;
      m_owner = N - 1; m_burst = 0;
      m_plot = 0; m_x = 0; m_y = 0; m_col = 0; m_clip = 0;
    end else if (g >= 0) begin
      m_burst = (g == m_owner) ? m_burst + 1 : 0;
      m_owner = g;
      m_live  = 1;
`ifdef PIXEL_ARB_CLIP_EN
      clp = (dx[g] >= 160) || (dy[g] >= 120);
`else
      clp = 0;
`endif
      m_plot = clp ? 0 : 1;
      m_x = dx[g]; m_y = dy[g]; m_col = dc[g];
      if (clp && m_clip < 65535) m_clip++;
    end else begin
      m_plot = 0;
    end
    #1;
    chk("plot", 32'(plot), m_plot);
    chk("x", 32'(x), m_x);
    chk("y", 32'(y), m_y);
    chk("colour", 32'(colour), m_col);
    chk("owner", 32'(owner), m_owner);
    chk("clip_cnt", 32'(clip_cnt), m_clip);
  endtask

  task automatic rand_data(int xmax, int ymax);
    for (int i = 0; i < N; i++) begin
      dx[i] = $urandom_range(xmax);
      dy[i] = $urandom_range(ymax);
      dc[i] = $urandom_range(7);
    end
  endtask

  initial begin
    sv.src_valid = '0;
    sv.src_x = '0;
    sv.src_y = '0;
    sv.src_colour = '0;
    hold  = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      dx[i] = 0; dy[i] = 0; dc[i] = 0;
    end
    @(posedge clock);
    #1;

    // reset state
    step(2'b00, 0, 1);
    chk("rst_owner", 32'(owner), N - 1);
    chk("rst_plot", 32'(plot), 0);

    // single pixel from source 0
    dx[0] = 10; dy[0] = 20; dc[0] = 4;
    step(2'b01, 0, 0);
    chk("t1_plot", 32'(plot), 1);
    chk("t1_x", 32'(x), 10);
    chk("t1_y", 32'(y), 20);
    chk("t1_colour", 32'(colour), 4);

    // both valid: bursts of four
    step(2'b00, 0, 1);
    for (int i = 0; i < 10; i++) begin
      rand_data(159, 119);
      step(2'b11, 0, 0);
      chk("t2_owner", 32'(owner), (i / 4) % 2);
    end

    // owner drops valid mid-burst
    step(2'b00, 0, 1);
    rand_data(159, 119);
    step(2'b11, 0, 0);
    step(2'b11, 0, 0);
    step(2'b10, 0, 0);
    chk("t3_owner", 32'(owner), 1);
    chk("t3_plot", 32'(plot), 1);

    // hold mid-burst freezes, burst resumes
    step(2'b00, 0, 1);
    step(2'b11, 0, 0);
    step(2'b11, 0, 0);
    for (int i = 0; i < 3; i++) step(2'b11, 1, 0);
    step(2'b11, 0, 0);
    step(2'b11, 0, 0);
    chk("t4_owner0", 32'(owner), 0);
    step(2'b11, 0, 0);
    chk("t4_owner1", 32'(owner), 1);

`ifdef PIXEL_ARB_CLIP_EN
    step(2'b00, 0, 1);
    dx[1] = 160; dy[1] = 5; dc[1] = 2;
    step(2'b10, 0, 0);
    chk("t5_plot_clip", 32'(plot), 0);
    chk("t5_cnt", 32'(clip_cnt), 1);
    dx[1] = 159; dy[1] = 119;
    step(2'b10, 0, 0);
    chk("t5_plot_edge", 32'(plot), 1);
`endif

    // reset coincident with a transfer
    step(2'b11, 0, 0);
    step(2'b11, 0, 1);
    chk("t6_plot", 32'(plot), 0);
    step(2'b11, 0, 0);
    chk("t6_owner", 32'(owner), 0);

    // randomized traffic, with some off-screen pixels
    for (int i = 0; i < 400; i++) begin
      rand_data(175, 127);
      step(2'($urandom), ($urandom_range(7) == 0),
           ($urandom_range(39) == 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
